// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Front-end fetch stage. Holds the PC and fetches one instruction at a time
//   over a valid/ready request + response-valid instruction-memory port. The
//   fetched word is held on instr/pc until the consumer retires it. Branch and
//   jump redirects replace the fetch PC. A response to a request that was
//   superseded by a redirect is discarded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    out  request valid (REQ state only)
//   imem_req_ready    in   memory accepts the request this cycle
//   imem_addr         out  fetch address
//   imem_rsp_valid    in   response word valid
//   imem_rsp_data     in   response instruction word
//   instr_valid       out  instr/pc hold a valid instruction
//   instr_ready       in   consumer retires the held instruction
//   instr             out  held instruction (NOP_INSTR when not valid)
//   pc, pc_plus4      out  address of the held instruction and that plus 4
//   redirect_valid    in   control-flow change request
//   redirect_target   in   new PC for the redirect
//   misalign_err      out  sticky flag: a redirect target was not 4-byte aligned
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = {XLEN{1'b0}},
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_err
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            drop_q, drop_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] redirect_pc_s;

  assign redirect_pc_s = {redirect_target[XLEN-1:2], 2'b00};

  // Next-state logic for the fetch FSM and its datapath registers.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    drop_d     = drop_q;
    misalign_d = misalign_q | (redirect_valid & (redirect_target[1:0] != 2'b00));

    case (state_q)
      S_REQ: begin
        fetch_pc_d = redirect_valid ? redirect_pc_s : fetch_pc_q;
        if (imem_req_ready) begin
          // The old address has been accepted; a concurrent redirect makes
          // its response stale.
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end else begin
          state_d = S_REQ;
          drop_d  = 1'b0;
        end
      end

      S_WAIT: begin
        fetch_pc_d = redirect_valid ? redirect_pc_s : fetch_pc_q;
        if (imem_rsp_valid) begin
          // The outstanding request completes here, so nothing remains to drop.
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
            instr_d = imem_rsp_data;
            pc_d    = fetch_pc_q;
          end
        end else begin
          state_d = S_WAIT;
          drop_d  = drop_q | redirect_valid;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          state_d    = S_REQ;
          fetch_pc_d = redirect_pc_s;
          instr_d    = NOP_INSTR;
        end else if (instr_ready) begin
          state_d    = S_REQ;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          instr_d    = NOP_INSTR;
        end else begin
          state_d    = S_HOLD;
        end
      end

      default: begin
        state_d    = S_REQ;
        drop_d     = 1'b0;
        instr_d    = NOP_INSTR;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  // Request is masked while reset is asserted so nothing is issued during reset.
  assign imem_req_valid = (state_q == S_REQ) & rst_n;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = (state_q == S_HOLD);
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + PC_STEP;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        misalign_err;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    int          hold;
  } vec_t;
  vec_t vecs[4];

  instr_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Wait (bounded) for a held instruction and compare it with the scoreboard.
  task automatic expect_hold();
    exp_t e;
    int n = 0;
    while (!instr_valid && n < 20) begin tick(); n++; end
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    check("sb_pending", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("instr", instr, e.data);
      check("pc", pc, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
    end
  endtask

  // Accept a request at addr, answer after delay cycles, and check it lands in HOLD.
  task automatic fetch_to_hold(input logic [31:0] addr, input logic [31:0] data, input int delay);
    int n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    check("req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("imem_addr", imem_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("req_valid_wait", {31'd0, imem_req_valid}, 32'd0);
    for (int i = 1; i < delay; i++) begin
      check("instr_valid_wait", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    sb_q.push_back('{pc: addr, data: data});
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    expect_hold();
  endtask

  task automatic retire();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("retired_valid", {31'd0, instr_valid}, 32'd0);
    check("retired_instr", instr, NOP);
  endtask

  task automatic redirect(input logic [31:0] tgt, input logic rdy, input logic irdy);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    imem_req_ready  = rdy;
    instr_ready     = irdy;
    tick();
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b0;
    instr_ready     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, data: 32'h0050_0093, delay: 1, hold: 0};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h00A0_0113, delay: 1, hold: 0};
    vecs[2] = '{addr: 32'h0000_0008, data: 32'h0020_81B3, delay: 1, hold: 5};
    vecs[3] = '{addr: 32'h0000_000C, data: 32'h4031_0233, delay: 3, hold: 0};

    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick(); tick();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'h0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_addr", imem_addr, 32'h0);

    // Free-running fetches, including backpressure in HOLD and a slow response.
    for (int v = 0; v < 4; v++) begin
      fetch_to_hold(vecs[v].addr, vecs[v].data, vecs[v].delay);
      for (int h = 0; h < vecs[v].hold; h++) begin
        tick();
        check("bp_instr", instr, vecs[v].data);
        check("bp_pc", pc, vecs[v].addr);
        check("bp_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("bp_instr_valid", {31'd0, instr_valid}, 32'd1);
      end
      retire();
    end

    // Redirect in HOLD together with instr_ready: pc+4 is never fetched.
    fetch_to_hold(32'h0000_0010, 32'h0000_0513, 1);
    redirect(32'h0000_0100, 1'b0, 1'b1);
    check("hold_redir_valid", {31'd0, instr_valid}, 32'd0);
    check("hold_redir_instr", instr, NOP);
    check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
    check("hold_redir_addr", imem_addr, 32'h0000_0100);

    // Redirect in WAIT; the response arrives 3 cycles later and is dropped.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect(32'h0000_0200, 1'b0, 1'b0);
    tick(); tick();
    check("wait_redir_valid", {31'd0, instr_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_0013;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check("wait_drop_valid", {31'd0, instr_valid}, 32'd0);
    check("wait_drop_instr", instr, NOP);
    check("wait_drop_req", {31'd0, imem_req_valid}, 32'd1);
    check("wait_drop_addr", imem_addr, 32'h0000_0200);
    fetch_to_hold(32'h0000_0200, 32'h0010_0593, 1);
    retire();

    // Redirect in REQ while the old address is accepted: its response is dropped.
    check("req_acc_addr_before", imem_addr, 32'h0000_0204);
    redirect(32'h0000_0300, 1'b1, 1'b0);
    check("req_acc_in_wait", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD1_0013;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check("req_acc_drop_valid", {31'd0, instr_valid}, 32'd0);
    check("req_acc_addr", imem_addr, 32'h0000_0300);

    // Misaligned redirect in REQ without ready.
    redirect(32'h0000_0102, 1'b0, 1'b0);
    check("mis_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("mis_addr", imem_addr, 32'h0000_0100);
    check("mis_err", {31'd0, misalign_err}, 32'd1);
    fetch_to_hold(32'h0000_0100, 32'h0020_0613, 2);
    retire();
    check("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC, 1'b0, 1'b0);
    fetch_to_hold(32'hFFFF_FFFC, 32'h0030_0693, 1);
    retire();
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset while in WAIT, then a late response.
    redirect(32'h0000_0040, 1'b0, 1'b0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("mid_rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("mid_rst_addr", imem_addr, 32'h0);
    #1;
    rst_n = 1'b1;
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD2_0013;
    tick();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    check("late_rsp_valid", {31'd0, instr_valid}, 32'd0);
    check("late_rsp_instr", instr, NOP);
    check("late_rsp_req", {31'd0, imem_req_valid}, 32'd1);
    check("late_rsp_addr", imem_addr, 32'h0);
    fetch_to_hold(32'h0000_0000, 32'h0040_0713, 1);
    retire();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
